// File: rtl/mestpro_mem_pkg.sv
// Shared memory-map defaults and the request sequencer state encoding.
// Imported by mem_bus_ctrl, its interface and the address checker.
package mestpro_mem_pkg;

  localparam int DEF_ADDR_BITS = 8;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_ROM_SIZE  = 128;
  localparam int DEF_MEM_SIZE  = 256;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    FAULT    = 3'd4
  } state_t;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Core request/response and memory pin bundle for mem_bus_ctrl.
// slave = controller side, master = core plus memory side.
interface mem_bus_ctrl_if #(
  parameter int ADDR_BITS = mestpro_mem_pkg::DEF_ADDR_BITS,
  parameter int DATA_BITS = mestpro_mem_pkg::DEF_DATA_BITS
);
  // Request transfers on a rising edge with req_valid & req_ready; fields are
  // sampled only at that edge. rsp_valid is a one-cycle strobe, never stalled.
  logic                 req_valid;
  logic                 req_we;
  logic [ADDR_BITS-1:0] req_addr;
  logic [DATA_BITS-1:0] req_wdata;
  logic                 req_ready;
  logic                 rsp_valid;
  logic [DATA_BITS-1:0] rsp_rdata;
  logic                 rsp_fault;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic                 mem_cs;
  logic                 mem_we;
  logic [DATA_BITS-1:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
    input  mem_addr, mem_wdata, mem_cs, mem_we
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
    output mem_addr, mem_wdata, mem_cs, mem_we
  );
endinterface

// File: rtl/mem_addr_check.sv
// Combinational range and ROM-protect decode. Compares at ADDR_BITS+1 bits
// so a fully populated map (MEM_SIZE = 2^ADDR_BITS) never faults on range.
module mem_addr_check
  import mestpro_mem_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int ROM_SIZE  = DEF_ROM_SIZE,
  parameter int MEM_SIZE  = DEF_MEM_SIZE
) (
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 we,
  output logic                 fault
);
  localparam logic [ADDR_BITS:0] MEM_LIM = (ADDR_BITS+1)'(MEM_SIZE);
  localparam logic [ADDR_BITS:0] ROM_LIM = (ADDR_BITS+1)'(ROM_SIZE);

  logic [ADDR_BITS:0] addr_ext;

  assign addr_ext = {1'b0, addr};
  assign fault    = (addr_ext >= MEM_LIM) | (we & (addr_ext < ROM_LIM));
endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-outstanding request sequencer in front of the program/data memory.
// Optional fault counter output enabled by MEM_BUS_CTRL_FAULT_CNT_EN.
module mem_bus_ctrl
  import mestpro_mem_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int ROM_SIZE  = DEF_ROM_SIZE,
  parameter int MEM_SIZE  = DEF_MEM_SIZE
) (
  input  logic                 CLK,
  input  logic                 RESET,
  mem_bus_ctrl_if.slave        bus,
`ifdef MEM_BUS_CTRL_FAULT_CNT_EN
  output logic [7:0]           fault_cnt,
`endif
  output state_t               dbg_state
);

  state_t               state, state_n;
  logic                 req_ready_n, rsp_valid_n, rsp_fault_n, mem_cs_n, mem_we_n;
  logic [DATA_BITS-1:0] rsp_rdata_n, mem_wdata_n;
  logic [ADDR_BITS-1:0] mem_addr_n;
  logic                 fault;
  logic                 accept;

  assign accept    = bus.req_valid & bus.req_ready;
  assign dbg_state = state;

  mem_addr_check #(
    .ADDR_BITS(ADDR_BITS),
    .ROM_SIZE (ROM_SIZE),
    .MEM_SIZE (MEM_SIZE)
  ) u_addr_check (
    .addr (bus.req_addr),
    .we   (bus.req_we),
    .fault(fault)
  );

  always_comb begin
    state_n     = state;
    req_ready_n = bus.req_ready;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = bus.rsp_rdata;
    rsp_fault_n = bus.rsp_fault;
    mem_cs_n    = bus.mem_cs;
    mem_we_n    = bus.mem_we;
    mem_addr_n  = bus.mem_addr;
    mem_wdata_n = bus.mem_wdata;
    case (state)
      IDLE: begin
        if (accept) begin
          mem_addr_n  = bus.req_addr;
          mem_wdata_n = bus.req_wdata;
          mem_we_n    = bus.req_we;
          mem_cs_n    = ~fault;
          req_ready_n = 1'b0;
          if (fault)            state_n = FAULT;
          else if (!bus.req_we) state_n = RD_ISSUE;
          else                  state_n = WR_ISSUE;
        end
      end
      RD_ISSUE: begin
        mem_cs_n = 1'b0;
        state_n  = RD_WAIT;
      end
      // Memory output registered at the RD_ISSUE exit edge is valid here.
      RD_WAIT: begin
        rsp_rdata_n = bus.mem_rdata;
        rsp_valid_n = 1'b1;
        rsp_fault_n = 1'b0;
        req_ready_n = 1'b1;
        state_n     = IDLE;
      end
      WR_ISSUE: begin
        mem_cs_n    = 1'b0;
        mem_we_n    = 1'b0;
        rsp_valid_n = 1'b1;
        rsp_fault_n = 1'b0;
        rsp_rdata_n = '0;
        req_ready_n = 1'b1;
        state_n     = IDLE;
      end
      FAULT: begin
        mem_we_n    = 1'b0;
        rsp_valid_n = 1'b1;
        rsp_fault_n = 1'b1;
        rsp_rdata_n = '0;
        req_ready_n = 1'b1;
        state_n     = IDLE;
      end
      default: begin
        mem_cs_n    = 1'b0;
        mem_we_n    = 1'b0;
        req_ready_n = 1'b1;
        state_n     = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_fault <= 1'b0;
      bus.mem_cs    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state         <= state_n;
      bus.req_ready <= req_ready_n;
      bus.rsp_valid <= rsp_valid_n;
      bus.rsp_rdata <= rsp_rdata_n;
      bus.rsp_fault <= rsp_fault_n;
      bus.mem_cs    <= mem_cs_n;
      bus.mem_we    <= mem_we_n;
      bus.mem_addr  <= mem_addr_n;
      bus.mem_wdata <= mem_wdata_n;
    end
  end

`ifdef MEM_BUS_CTRL_FAULT_CNT_EN
  // Clearing by a read of the top address only exists for a fully populated map.
  localparam bit                   CLR_EN   = (MEM_SIZE == (1 << ADDR_BITS));
  localparam logic [ADDR_BITS-1:0] TOP_ADDR = ADDR_BITS'(MEM_SIZE - 1);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fault_cnt <= '0;
    end else if (state == FAULT) begin
      if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
    end else if (CLR_EN && accept && !bus.req_we && (bus.req_addr == TOP_ADDR)) begin
      fault_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: default map instance plus a MEM_SIZE=200
// instance; fault counter checks compile in with MEM_BUS_CTRL_FAULT_CNT_EN.
module tb_mem_bus_ctrl;
  import mestpro_mem_pkg::*;

  // Scoreboard entry: {due cycle[15:0], fault, rdata[7:0]}
  localparam int W = 25;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_bus_ctrl_if #(.ADDR_BITS(8), .DATA_BITS(8)) bus ();
  mem_bus_ctrl_if #(.ADDR_BITS(8), .DATA_BITS(8)) bus2 ();
  state_t dbg_state, dbg_state2;
`ifdef MEM_BUS_CTRL_FAULT_CNT_EN
  logic [7:0] fault_cnt, fault_cnt2;
`endif

  mem_bus_ctrl dut (
    .CLK      (clk),
    .RESET    (rst_n),
    .bus      (bus),
`ifdef MEM_BUS_CTRL_FAULT_CNT_EN
    .fault_cnt(fault_cnt),
`endif
    .dbg_state(dbg_state)
  );

  mem_bus_ctrl #(.MEM_SIZE(200)) dut2 (
    .CLK      (clk),
    .RESET    (rst_n),
    .bus      (bus2),
`ifdef MEM_BUS_CTRL_FAULT_CNT_EN
    .fault_cnt(fault_cnt2),
`endif
    .dbg_state(dbg_state2)
  );

  // ---------------- memory models and free-running cycle count ----------------
  logic [7:0]  mem [256];
  logic        mem_init = 1'b0;
  logic [15:0] cyc      = 16'd0;

  always @(posedge clk) cyc <= cyc + 16'd1;

  // ROM byte i holds i ^ 0x5A, RAM starts at zero.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i < 128) ? (8'(i) ^ 8'h5A) : 8'h00;
      mem_init <= 1'b1;
    end else if (bus.mem_cs) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  always @(posedge clk) begin
    if (bus2.mem_cs && !bus2.mem_we) bus2.mem_rdata <= bus2.mem_addr ^ 8'h3C;
  end

  int         cs_cnt = 0;
  int         we_cnt = 0;
  logic [7:0] last_cs_addr = 8'h00;

  always @(negedge clk) begin
    if (bus.mem_cs) begin
      cs_cnt       <= cs_cnt + 1;
      last_cs_addr <= bus.mem_addr;
      if (bus.mem_we) we_cnt <= we_cnt + 1;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic score(input string tag, input logic [W-1:0] e, input logic f,
                       input logic [7:0] d, input logic [15:0] now);
    check({tag, " rsp_fault"},   32'(f),   32'(e[8]));
    check({tag, " rsp_rdata"},   32'(d),   32'(e[7:0]));
    check({tag, " rsp latency"}, 32'(now), 32'(e[24:9]));
  endtask

  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) check("dut unexpected rsp_valid", 32'(bus.rsp_valid), 32'd0);
      else score("dut", exp_q.pop_front(), bus.rsp_fault, bus.rsp_rdata, cyc);
    end
  end

  always @(negedge clk) begin
    if (bus2.rsp_valid) begin
      if (exp_q2.size() == 0) check("dut2 unexpected rsp_valid", 32'(bus2.rsp_valid), 32'd0);
      else score("dut2", exp_q2.pop_front(), bus2.rsp_fault, bus2.rsp_rdata, cyc);
    end
  end

  // ---------------- driver ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one request and returns 1 time unit after its accept edge.
  task automatic issue(input bit sel, input bit we, input logic [7:0] addr,
                       input logic [7:0] wdata, input bit expect_rsp,
                       input bit exp_fault, input logic [7:0] exp_rdata, input bit keep);
    logic [15:0]  n;
    logic [W-1:0] e;
    bit           done = 1'b0;
    logic         rdy;
    if (sel) begin
      bus2.req_valid = 1'b1; bus2.req_we = we; bus2.req_addr = addr; bus2.req_wdata = wdata;
    end else begin
      bus.req_valid  = 1'b1; bus.req_we  = we; bus.req_addr  = addr; bus.req_wdata  = wdata;
    end
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      rdy = sel ? bus2.req_ready : bus.req_ready;
      if (rdy === 1'b1) begin
        n = cyc + 16'd1;
        if (expect_rsp) begin
          e = {n + ((!we && !exp_fault) ? 16'd2 : 16'd1), exp_fault, exp_rdata};
          if (sel) exp_q2.push_back(e);
          else     exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check("accept timeout", 32'(done), 32'd1);
    if (!keep) begin
      bus.req_valid  = 1'b0;
      bus2.req_valid = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  int         cs0, we0;
  logic [7:0] rdy_seen;

  initial begin
    bus.req_valid  = 1'b0; bus.req_we  = 1'b0; bus.req_addr  = 8'h00; bus.req_wdata  = 8'h00;
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = 8'h00; bus2.req_wdata = 8'h00;
    rdy_seen = 8'h00;

    idle(3);
    check("reset req_ready", 32'(bus.req_ready), 32'd1);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("reset rsp_fault", 32'(bus.rsp_fault), 32'd0);
    check("reset mem_cs",    32'(bus.mem_cs),    32'd0);
    check("reset mem_we",    32'(bus.mem_we),    32'd0);
    check("reset mem_addr",  32'(bus.mem_addr),  32'd0);
    check("reset mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("reset state",     32'(dbg_state),     32'(IDLE));
    rst_n = 1'b1;
    idle(1);

    // RAM write then read-back
    cs0 = cs_cnt; we0 = we_cnt;
    issue(1'b0, 1'b1, 8'h90, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
    idle(3);
    check("write cs cycles", 32'(cs_cnt - cs0), 32'd1);
    check("write we cycles", 32'(we_cnt - we0), 32'd1);
    check("write mem_addr",  32'(last_cs_addr), 32'h90);
    issue(1'b0, 1'b0, 8'h90, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0);
    idle(3);

    // ROM write is blocked, ROM content unchanged
    cs0 = cs_cnt;
    issue(1'b0, 1'b1, 8'h10, 8'h33, 1'b1, 1'b1, 8'h00, 1'b0);
    idle(3);
    check("rom write cs cycles", 32'(cs_cnt - cs0), 32'd0);
    issue(1'b0, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h4A, 1'b0);
    idle(3);

    // ROM/RAM boundary
    issue(1'b0, 1'b1, 8'h7F, 8'h11, 1'b1, 1'b1, 8'h00, 1'b0);
    issue(1'b0, 1'b1, 8'h80, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0);
    idle(2);

    // Back-to-back with req_valid held high
    fork
      begin
        issue(1'b0, 1'b1, 8'h80, 8'h5C, 1'b1, 1'b0, 8'h00, 1'b1);
        issue(1'b0, 1'b0, 8'h80, 8'h00, 1'b1, 1'b0, 8'h5C, 1'b1);
        issue(1'b0, 1'b1, 8'hFF, 8'hE1, 1'b1, 1'b0, 8'h00, 1'b0);
      end
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          rdy_seen[i] = bus.req_ready;
        end
      end
    join
    check("b2b req_ready pattern", 32'(rdy_seen), 32'hA5);
    idle(2);

`ifdef MEM_BUS_CTRL_FAULT_CNT_EN
    check("fault_cnt after two faults", 32'(fault_cnt), 32'd2);
`endif
    issue(1'b0, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'hE1, 1'b0);
    idle(3);
`ifdef MEM_BUS_CTRL_FAULT_CNT_EN
    check("fault_cnt cleared by top read", 32'(fault_cnt), 32'd0);
`endif

    // Partially populated map: range edge at 200
    issue(1'b1, 1'b0, 8'hC8, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
    idle(2);
    issue(1'b1, 1'b0, 8'hC7, 8'h00, 1'b1, 1'b0, 8'hFB, 1'b0);
    idle(3);

    // Reset during RD_ISSUE
    issue(1'b0, 1'b0, 8'h90, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    check("rd abort state before reset", 32'(dbg_state), 32'(RD_ISSUE));
    check("rd abort mem_cs before reset", 32'(bus.mem_cs), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rd abort mem_cs", 32'(bus.mem_cs), 32'd0);
    check("rd abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rd abort req_ready", 32'(bus.req_ready), 32'd1);
    check("rd abort state", 32'(dbg_state), 32'(IDLE));
    idle(2);
    rst_n = 1'b1;
    idle(3);

    // Reset during WR_ISSUE: the write must not land
    issue(1'b0, 1'b1, 8'hA0, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0);
    check("wr abort state before reset", 32'(dbg_state), 32'(WR_ISSUE));
    check("wr abort mem_we before reset", 32'(bus.mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("wr abort mem_cs", 32'(bus.mem_cs), 32'd0);
    check("wr abort mem_we", 32'(bus.mem_we), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    issue(1'b0, 1'b0, 8'hA0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    idle(3);

`ifdef MEM_BUS_CTRL_FAULT_CNT_EN
    for (int i = 0; i < 300; i++) begin
      issue(1'b0, 1'b1, 8'(i % 128), 8'(i), 1'b1, 1'b1, 8'h00, 1'b0);
    end
    idle(2);
    check("fault_cnt saturates", 32'(fault_cnt), 32'd255);
    issue(1'b0, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 8'hE1, 1'b0);
    idle(3);
    check("fault_cnt cleared after saturation", 32'(fault_cnt), 32'd0);
`endif

    for (int t = 0; t < 20 && (exp_q.size() + exp_q2.size()) != 0; t++) @(posedge clk);
    check("scoreboard drained", 32'(exp_q.size() + exp_q2.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
